udp_cmac_pkt_reflector: RTL and testbench
=========================================

# udp_cmac_pkt_reflector

Store-and-forward AXI-Stream packet reflector for the far end of the UDP/CMAC performance link. It receives 512-bit frames from the CMAC RX stream and buffers each complete frame. It swaps the Ethernet destination and source MAC addresses, then retransmits the frame on the CMAC TX stream, so the perf monitor's generator sees its own traffic return. Malformed or overflowing frames are dropped whole, and the drops are counted.

## Interface
- DATA_WIDTH, 512, AXIS tdata width
- KEEP_WIDTH, 64, AXIS tkeep width (DATA_WIDTH/8)
- USER_WIDTH, 1, AXIS tuser width; bit 0 = frame error on last beat
- BUF_DEPTH, 64, buffer depth in beats; power of two, at least 2
- CLK  in  1  single clock for all logic
- RST_N  in  1  reset; asynchronous, active-low
- reflect_en  in  1  1 = reflect frames; 0 = drop all new frames
- swap_mac_en  in  1  1 = swap MAC fields in the first beat
- s_axis_tvalid/tdata/tkeep/tlast/tuser  in  1/DATA_WIDTH/KEEP_WIDTH/1/USER_WIDTH  RX stream from CMAC
- s_axis_tready  out  1  constant 1; the CMAC RX path has no backpressure
- m_axis_tvalid/tdata/tkeep/tlast/tuser  out  1/DATA_WIDTH/KEEP_WIDTH/1/USER_WIDTH  TX stream to CMAC
- m_axis_tready  in  1  TX backpressure
- reflected_pkt_cnt  out  32  frames fully transmitted; wraps
- dropped_pkt_cnt  out  32  frames discarded; wraps
- buf_level  out  $clog2(BUF_DEPTH)+1  committed beats not yet read

## Operation
- Pointers are $clog2(BUF_DEPTH)+1 bits wide, with a wrap bit:
  - wr_ptr is the speculative write position.
  - commit_ptr is the end of the last good frame.
  - rd_ptr is the TX read position.
- The buffer is full when wr_ptr - rd_ptr == BUF_DEPTH. It is empty for TX when rd_ptr == commit_ptr.
- RX FSM states:
  - IDLE: on the first beat, go to DROP if reflect_en=0; otherwise write the beat and go to RECV. A single-beat frame with tlast is handled exactly as the last beat in RECV.
  - RECV: write each beat (tdata, tkeep, tlast) at wr_ptr and advance it. On a beat with tlast=1:
    - tuser[0]=0: commit_ptr <= wr_ptr+1, go to IDLE.
    - tuser[0]=1: wr_ptr <= commit_ptr, increment dropped_pkt_cnt, go to IDLE.
  - Overflow: a beat arriving in RECV while full sets wr_ptr <= commit_ptr and goes to DROP. If that beat has tlast, increment dropped_pkt_cnt and return to IDLE immediately.
  - DROP: discard beats. On tlast, increment dropped_pkt_cnt and go to IDLE.
- reflect_en is sampled only at frame start; changing it mid-frame has no effect on that frame.
- TX FSM states:
  - IDLE: when committed data exists, issue a read and go to SEND.
  - SEND: present the read beat through an output register with a one-entry skid, so the stream sustains one beat per cycle under continuous tready.
    - First beat of a frame with swap_mac_en=1 at issue: tdata[47:0] <= mem[95:48] and tdata[95:48] <= mem[47:0]; all other bits pass through unchanged.
    - m_axis_tuser = 0 always.
    - When a tlast beat is accepted, increment reflected_pkt_cnt.
- Simultaneous RX commit and TX read on the same cycle are legal. buf_level = commit_ptr - rd_ptr, modulo 2^width.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0, both counters=0, buf_level=0, all pointers=0, both FSMs IDLE.
- RAM read latency is 1 cycle. With TX idle, a frame whose tlast is accepted at cycle t has its first beat valid at t+2.
- m_axis_tvalid, once asserted, stays high with data stable until tready. Inside a frame it never drops while the buffer holds that frame's beats (guaranteed, since whole frames are committed).
- Counters update on the cycle after the triggering event.
- Reset mid-frame discards all buffered content; no partial frame is emitted after reset.

## Structure
- Shared package udp_cmac_pkg: MAC_DST_LSB=0, MAC_SRC_LSB=48, MAC_WIDTH=48, and an axis_beat_t struct of {tdata, tkeep, tlast} used as the RAM word.
- One sub-module, udp_cmac_reflect_ram: simple dual-port RAM with BUF_DEPTH x (DATA_WIDTH+KEEP_WIDTH+1) words, synchronous write, 1-cycle registered read, no reset on the array.

## Test plan
- Single-beat frame: tkeep=64'hFFFF_FFFF_FFFF_FFFF, dst=0x112233445566, src=0xAABBCCDDEEFF, swap on, tready=1.
  - Out at t+2: dst=0xAABBCCDDEEFF, src=0x112233445566, remaining bytes equal.
  - reflected_pkt_cnt=1.
- 3-beat frame, last tkeep=64'h0000_0000_0000_000F, tready toggling 1/0 every cycle.
  - 3 beats out in order, tkeep preserved, tlast only on beat 3, data stable while stalled.
- 3-beat frame with tuser=1 on the last beat.
  - Nothing transmitted; dropped_pkt_cnt=1; buf_level returns to 0.
- BUF_DEPTH=64, tready=0, eight 8-beat frames then a ninth 8-beat frame.
  - First 8 committed (buf_level=64); ninth dropped (dropped_pkt_cnt=1).
  - Releasing tready emits exactly 8 frames, reflected_pkt_cnt=8.
- reflect_en=0 during frame A, raised mid-frame A, then frame B.
  - A dropped, B reflected; counts 1/1.
- Assert RST_N=0 in the middle of receiving a 4-beat frame, then send a 2-beat frame.
  - Only the 2-beat frame appears; counters are 1 reflected, 0 dropped.

Source files
------------

// File: rtl/udp_cmac_pkg.sv
// udp_cmac_pkg: shared MAC field positions, RAM beat type and MAC swap helper
package udp_cmac_pkg;
  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = 64;
  localparam int AXIS_USER_W = 1;
  localparam int MAC_DST_LSB = 0;
  localparam int MAC_SRC_LSB = 48;
  localparam int MAC_WIDTH   = 48;
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
  } axis_beat_t;
  function automatic axis_beat_t swap_mac(input axis_beat_t b);
    axis_beat_t r;
    r = b;
    r.tdata[MAC_DST_LSB +: MAC_WIDTH] = b.tdata[MAC_SRC_LSB +: MAC_WIDTH];
    r.tdata[MAC_SRC_LSB +: MAC_WIDTH] = b.tdata[MAC_DST_LSB +: MAC_WIDTH];
    return r;
  endfunction
endpackage

// File: rtl/udp_cmac_pkt_reflector_if.sv
// udp_cmac_pkt_reflector_if: AXI-Stream bundle (tvalid/tready/tdata/tkeep/tlast/tuser)
// master drives payload and valid, slave drives tready.
interface udp_cmac_pkt_reflector_if
  import udp_cmac_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int KEEP_WIDTH = AXIS_KEEP_W,
  parameter int USER_WIDTH = AXIS_USER_W
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  modport master(output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave(input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/udp_cmac_reflect_ram.sv
// udp_cmac_reflect_ram: simple dual-port frame buffer, sync write, 1-cycle registered read
// ports: clk, we/waddr/wdata write side, re/raddr/rdata read side; array is not reset.
module udp_cmac_reflect_ram
  import udp_cmac_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  axis_beat_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output axis_beat_t    rdata
);
  axis_beat_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/udp_cmac_pkt_reflector.sv
// udp_cmac_pkt_reflector: store-and-forward frame reflector with MAC swap and drop counting
// ports: clk, rst_n (async, active-low), reflect_en, swap_mac_en, s_axis (RX, never stalls),
// m_axis (TX), reflected_pkt_cnt, dropped_pkt_cnt, buf_level (committed beats not yet sent).
module udp_cmac_pkt_reflector
  import udp_cmac_pkg::*;
#(
  parameter int BUF_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        reflect_en,
  input  logic                        swap_mac_en,
  udp_cmac_pkt_reflector_if.slave     s_axis,
  udp_cmac_pkt_reflector_if.master    m_axis,
  output logic [31:0]                 reflected_pkt_cnt,
  output logic [31:0]                 dropped_pkt_cnt,
  output logic [$clog2(BUF_DEPTH):0]  buf_level
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_state_t;
  rx_state_t rx_state;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, rd_addr;
  logic full, rx_take, wr_en, issue, consume, rd_pend, swap_pend, rd_first, out_v, sk_v;
  logic [1:0] occ;
  axis_beat_t wr_beat, rd_beat, tx_beat, out_q, sk_q;
  // rd_ptr only moves on TX acceptance, so beats sitting in the output/skid
  // registers still count as occupied and cannot be overwritten.
  assign full = (wr_ptr - rd_ptr) == PW'(BUF_DEPTH);
  assign rx_take = rx_state == RX_RECV || (rx_state == RX_IDLE && reflect_en);
  assign wr_en = s_axis.tvalid && rx_take && !full;
  assign wr_beat = '{tdata: s_axis.tdata, tkeep: s_axis.tkeep, tlast: s_axis.tlast};
  assign s_axis.tready = 1'b1;
  assign consume = out_v && m_axis.tready;
  // beats held next cycle; a new read may only be issued if its data will fit
  assign occ = 2'(out_v) + 2'(sk_v) + 2'(rd_pend) - 2'(consume);
  assign issue = rd_addr != commit_ptr && occ <= 2'd1;
  assign tx_beat = rd_first && swap_pend ? swap_mac(rd_beat) : rd_beat;
  assign buf_level = commit_ptr - rd_ptr;
  assign m_axis.tvalid = out_v;
  assign m_axis.tdata = out_q.tdata;
  assign m_axis.tkeep = out_q.tkeep;
  assign m_axis.tlast = out_q.tlast;
  assign m_axis.tuser = '0;
  udp_cmac_reflect_ram #(.DEPTH(BUF_DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_beat),
    .re    (issue),
    .raddr (rd_addr[AW-1:0]),
    .rdata (rd_beat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      dropped_pkt_cnt <= '0;
    end else if (s_axis.tvalid) begin
      if (rx_take && full) begin
        wr_ptr <= commit_ptr;
        rx_state <= s_axis.tlast ? RX_IDLE : RX_DROP;
        dropped_pkt_cnt <= dropped_pkt_cnt + 32'(s_axis.tlast);
      end else if (rx_take) begin
        wr_ptr <= s_axis.tlast && s_axis.tuser[0] ? commit_ptr : wr_ptr + PW'(1);
        if (s_axis.tlast && !s_axis.tuser[0]) commit_ptr <= wr_ptr + PW'(1);
        dropped_pkt_cnt <= dropped_pkt_cnt + 32'(s_axis.tlast && s_axis.tuser[0]);
        rx_state <= s_axis.tlast ? RX_IDLE : RX_RECV;
      end else begin
        dropped_pkt_cnt <= dropped_pkt_cnt + 32'(s_axis.tlast);
        rx_state <= s_axis.tlast ? RX_IDLE : RX_DROP;
      end
    end
  end
  // rd_first tracks frame starts on the returning read data; swap_pend is
  // swap_mac_en captured on the cycle the read was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      rd_addr <= '0;
      rd_pend <= 1'b0;
      swap_pend <= 1'b0;
      rd_first <= 1'b1;
      out_v <= 1'b0;
      sk_v <= 1'b0;
      out_q <= '0;
      sk_q <= '0;
      reflected_pkt_cnt <= '0;
    end else begin
      rd_pend <= issue;
      swap_pend <= swap_mac_en;
      rd_addr <= rd_addr + PW'(issue);
      if (rd_pend) rd_first <= rd_beat.tlast;
      if (consume) rd_ptr <= rd_ptr + PW'(1);
      if (consume && out_q.tlast) reflected_pkt_cnt <= reflected_pkt_cnt + 32'd1;
      if (!out_v || consume) begin
        out_v <= sk_v || rd_pend;
        if (sk_v) out_q <= sk_q;
        else if (rd_pend) out_q <= tx_beat;
        sk_v <= sk_v && rd_pend;
        if (sk_v && rd_pend) sk_q <= tx_beat;
      end else if (rd_pend) begin
        sk_v <= 1'b1;
        sk_q <= tx_beat;
      end
    end
  end
endmodule

// File: tb/tb_udp_cmac_pkt_reflector.sv
// tb_udp_cmac_pkt_reflector: randomized self-checking bench with a frame-level reference model
module tb_udp_cmac_pkt_reflector;
  typedef struct {logic [511:0] d; logic [63:0] k; logic l;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0, reflect_en = 1'b1, swap_mac_en = 1'b1;
  logic [31:0] refl_cnt, drop_cnt;
  logic [6:0] buf_level;
  beat_t exp_q[$];
  int n_checks = 0, n_err = 0, exp_refl = 0, exp_drop = 0, rdy_mode = 0;
  logic stall = 1'b0, hl;
  logic [511:0] hd;
  logic [63:0] hk;
  udp_cmac_pkt_reflector_if s_if ();
  udp_cmac_pkt_reflector_if m_if ();
  udp_cmac_pkt_reflector #(.BUF_DEPTH(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .reflect_en        (reflect_en),
    .swap_mac_en       (swap_mac_en),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .reflected_pkt_cnt (refl_cnt),
    .dropped_pkt_cnt   (drop_cnt),
    .buf_level         (buf_level)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? !m_if.tready :
                    rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) stall = 1'b0;
    else begin
      if (stall) begin
        check("hold_valid", 512'(m_if.tvalid), 512'(1));
        check("hold_data", m_if.tdata, hd);
        check("hold_keep", 512'(m_if.tkeep), 512'(hk));
        check("hold_last", 512'(m_if.tlast), 512'(hl));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) check("extra_beat", 512'(exp_q.size()), 512'(1));
        else begin : pop
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", m_if.tdata, e.d);
          check("out_keep", 512'(m_if.tkeep), 512'(e.k));
          check("out_last", 512'(m_if.tlast), 512'(e.l));
          check("out_user", 512'(m_if.tuser), 512'(0));
          if (e.l) exp_refl++;
        end
      end
      stall = m_if.tvalid && !m_if.tready;
      hd = m_if.tdata;
      hk = m_if.tkeep;
      hl = m_if.tlast;
    end
  end
  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l, input logic u);
    s_if.tvalid = 1'b1;
    s_if.tdata = d;
    s_if.tkeep = k;
    s_if.tlast = l;
    s_if.tuser = u;
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask
  task automatic send_frame(input int n, input bit err, input bit keep_it, input bit swap,
                            input logic [63:0] lk, input logic [95:0] hdr);
    for (int i = 0; i < n; i++) begin : beat
      logic [511:0] d;
      logic [63:0] k;
      beat_t e;
      d = rnd512();
      if (i == 0 && hdr != 0) d[95:0] = hdr;
      k = i == n - 1 ? lk : '1;
      e.d = d;
      e.k = k;
      e.l = i == n - 1;
      if (i == 0 && swap) begin
        e.d[47:0] = d[95:48];
        e.d[95:48] = d[47:0];
      end
      if (keep_it) exp_q.push_back(e);
      drive_beat(d, k, i == n - 1, err && i == n - 1);
    end
    if (!keep_it) exp_drop++;
  endtask
  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check("drain_timeout", 512'(c < 3000), 512'(1));
    repeat (4) @(posedge clk);
    #1;
    check("idle_valid", 512'(m_if.tvalid), 512'(0));
  endtask
  task automatic check_counts(input string tag);
    check({tag, "_refl"}, 512'(refl_cnt), 512'(exp_refl));
    check({tag, "_drop"}, 512'(drop_cnt), 512'(exp_drop));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tlast = 1'b0;
    s_if.tuser = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 512'(m_if.tvalid), 512'(0));
    check("rst_data", m_if.tdata, 512'(0));
    check("rst_keep_last", 512'({m_if.tkeep, m_if.tlast, m_if.tuser}), 512'(0));
    check("rst_buf_level", 512'(buf_level), 512'(0));
    check_counts("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(1, 0, 1, 1, '1, {48'hAABBCCDDEEFF, 48'h112233445566});
    check("lat_t0", 512'(m_if.tvalid), 512'(0));
    @(posedge clk);
    #1;
    check("lat_t1", 512'(m_if.tvalid), 512'(0));
    @(posedge clk);
    #1;
    check("lat_t2", 512'(m_if.tvalid), 512'(1));
    check("swap_dst", 512'(m_if.tdata[47:0]), 512'(48'hAABBCCDDEEFF));
    check("swap_src", 512'(m_if.tdata[95:48]), 512'(48'h112233445566));
    wait_drain();
    check_counts("single");
    rdy_mode = 1;
    send_frame(3, 0, 1, 1, 64'hF, '0);
    wait_drain();
    check_counts("toggle");
    rdy_mode = 0;
    send_frame(3, 1, 0, 1, '1, '0);
    repeat (4) @(posedge clk);
    #1;
    check("err_valid", 512'(m_if.tvalid), 512'(0));
    check("err_buf_level", 512'(buf_level), 512'(0));
    check_counts("err");
    rdy_mode = 3;
    @(posedge clk);
    #1;
    for (int f = 0; f < 8; f++) send_frame(8, 0, 1, 1, '1, '0);
    send_frame(8, 0, 0, 1, '1, '0);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_buf_level", 512'(buf_level), 512'(64));
    check_counts("ovf_full");
    rdy_mode = 0;
    wait_drain();
    check_counts("ovf_drain");
    reflect_en = 1'b0;
    drive_beat(rnd512(), '1, 1'b0, 1'b0);
    reflect_en = 1'b1;
    drive_beat(rnd512(), '1, 1'b0, 1'b0);
    drive_beat(rnd512(), '1, 1'b1, 1'b0);
    exp_drop++;
    send_frame(2, 0, 1, 1, 64'hFF, '0);
    wait_drain();
    check_counts("ren");
    for (int p = 0; p < 6; p++) begin
      bit sw;
      sw = 1'($urandom_range(0, 1));
      swap_mac_en = sw;
      rdy_mode = 2;
      for (int f = 0; f < 6; f++) begin
        int n;
        bit err, ren;
        n = $urandom_range(1, 8);
        err = $urandom_range(0, 4) == 0;
        ren = $urandom_range(0, 3) != 0;
        reflect_en = ren;
        send_frame(n, err, ren && !err, sw, 64'($urandom()) | 64'h1, '0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
      reflect_en = 1'b1;
      wait_drain();
      check_counts("rand");
    end
    rdy_mode = 0;
    swap_mac_en = 1'b1;
    drive_beat(rnd512(), '1, 1'b0, 1'b0);
    drive_beat(rnd512(), '1, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_refl = 0;
    exp_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_valid", 512'(m_if.tvalid), 512'(0));
    check("mid_rst_buf_level", 512'(buf_level), 512'(0));
    check_counts("mid_rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(2, 0, 1, 1, 64'h3, '0);
    wait_drain();
    check_counts("post_rst");
    check("post_rst_buf_level", 512'(buf_level), 512'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
